fm_discriminator: RTL and testbench
===================================

# fm_discriminator

Parametrised FM discriminator for the receive chain, placed directly after the CORDIC stage. It consumes {angle, magnitude} samples over AXI-Stream and computes the modulo-wrapped phase derivative. It also provides run-time squelch, integrate-and-dump decimation by DECIM, arithmetic scaling, and saturation to OUT_W. Output is a sign-extended audio sample stream for the audio filter and decimator.

## Interface
Parameters:
- ANGLE_W, 16: angle width; full scale 2^ANGLE_W = 2π, unsigned, in s00 tdata[16 +: ANGLE_W]
- MAG_W, 16: magnitude width, unsigned, in s00 tdata[MAG_W-1:0]
- DECIM, 1: decimation factor, legal 1..256
- SHIFT, 0: arithmetic right shift applied to the dump sum, legal 0..ANGLE_W+8
- OUT_W, 16: signed output width after saturation, legal 2..32

Ports:
- s00_axis_aclk, in, 1: the single clock
- s00_axis_aresetn, in, 1: reset, synchronous, active-high despite the name
- squelch_thresh, in, MAG_W: magnitude below this forces the difference to 0; a value of 0 disables squelch; sampled on each accept
- s00_axis_tvalid / s00_axis_tready, in / out, 1: input handshake
- s00_axis_tdata, in, 32: {angle, magnitude}
- s00_axis_tlast, in, 1: frame end
- s00_axis_tstrb, in, 4: ignored
- m00_axis_tvalid / m00_axis_tready, out / in, 1: output handshake
- m00_axis_tdata, out, 32: saturated result, sign-extended from OUT_W to 32 bits
- m00_axis_tlast, out, 1: set on the dump that closes a frame
- m00_axis_tstrb, out, 4: constant 4'hF

## Operation
- An input is accepted on a cycle where s00_axis_tvalid && s00_axis_tready.
- diff = (angle − prev_angle) mod 2^ANGLE_W, interpreted as signed ANGLE_W bits. Range is [−2^(ANGLE_W−1), 2^(ANGLE_W−1)−1], which gives implicit phase unwrap.
- Unprimed: the first accept after reset or after a tlast has no reference angle, so diff = 0. That accept sets primed.
- Squelch: if squelch_thresh ≠ 0 and mag < squelch_thresh, diff = 0.
  - prev_angle is updated on every accept, whether or not squelch is active.
- Accumulator: signed, ANGLE_W+9 bits. cnt counts 0..DECIM−1.
- Dump condition: cnt == DECIM−1, or s00_axis_tlast on an accepted beat.
- On a dump:
  - result = sat_OUT_W((acc + diff) >>> SHIFT).
  - Load the output register; m00_axis_tvalid = 1; m00_axis_tlast = the input tlast.
  - acc ← 0; cnt ← 0.
- On an accept without a dump: acc ← acc + diff; cnt ← cnt + 1.
- On tlast: the partial group is dumped as above, primed is cleared, and prev_angle is treated as invalid.
- Saturation: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].

## Timing
- s00_axis_tready = m00_axis_tready || !m00_axis_tvalid (combinational).
  - A dump can therefore never overwrite an unconsumed output.
- Latency: m00_axis_tvalid rises one cycle after the accept that causes a dump.
- Throughput: one input per cycle while downstream is ready.
- m00_axis_tvalid clears on m00_axis_tready && !new_dump. On m00_axis_tready together with a new dump in the same cycle, the register reloads and tvalid stays 1.
- Under m00_axis_tready = 0, m00_axis_tdata and m00_axis_tlast hold stable.
- Reset values, one cycle after reset is asserted:
  - m00_axis_tvalid = 0, m00_axis_tlast = 0, m00_axis_tdata = 0
  - acc = 0, cnt = 0, primed = 0, prev_angle = 0
- Reset mid-group discards the partial sum. Reset mid-stall drops the held output.
- Wrap: cnt wraps at DECIM−1 only; acc cannot overflow for DECIM ≤ 256.

## Structure
- Package fm_demod_pkg holds:
  - field offsets ANGLE_LSB = 16 and MAG_LSB = 0
  - a parameter-check macro or assertion covering the legal ranges
  - function sat_shift(signed value, shift, out_w)
- One natural sub-module: fm_sat_shift (combinational shift + clamp), so scaling and saturation can be reused by the audio decimator.
- Remaining sequential logic stays in fm_discriminator: accept, prime, accumulate, dump, output register.

## Test plan
- DECIM=1, SHIFT=0, squelch off.
  - Stimulus: angles 0x1000, 0x1400, 0x1300.
  - Required outputs: 0x00000000 (unprimed), 0x00000400, 0xFFFFFF00.
- Wrap.
  - Stimulus: angles 0xFF00, 0x0100.
  - Required second output: 0x00000200, not −0xFE00.
  - Also 0x0100 → 0xFF00 gives 0xFFFFFE00.
- DECIM=4, SHIFT=2.
  - Stimulus: angles 0x000, 0x100, … 0x700.
  - Required outputs: exactly two, 0x000000C0 then 0x00000100.
  - tvalid rises one cycle after the 4th and 8th accepts.
- Squelch.
  - Setup: thresh = 0x0100, DECIM=1.
  - Stimulus: mags 0x0200, 0x0080, 0x0200 with angles 0, 0x400, 0x800.
  - Required outputs: 0, 0, 0x400.
- Saturation and tlast.
  - Setup: OUT_W=8.
  - Stimulus: diff 0x0400.
  - Required: 0x0000007F; diff −0x0400 gives 0xFFFFFF80.
  - With DECIM=4, a tlast on the 2nd beat dumps a partial sum with tlast = 1. The next beat is unprimed (0).
- Backpressure and reset.
  - Stimulus: hold m00_axis_tready = 0 for 10 cycles during streaming.
  - Required: tvalid and tdata stable, s00_axis_tready = 0, no samples lost or duplicated after release.
  - Stimulus: assert reset mid-group.
  - Required: tvalid = 0 the next cycle, and the next output is unprimed.

Source files
------------

// File: rtl/fm_demod_pkg.sv
// fm_demod_pkg: shared field offsets, parameter legality check and scale/saturate helper
package fm_demod_pkg;
  localparam int ANGLE_LSB = 16;
  localparam int MAG_LSB = 0;
  function automatic bit params_ok(input int angle_w, input int mag_w, input int decim,
                                   input int shift, input int out_w);
    return angle_w >= 1 && angle_w <= 16 && mag_w >= 1 && mag_w <= 16 &&
           decim >= 1 && decim <= 256 && shift >= 0 && shift <= angle_w + 8 &&
           out_w >= 2 && out_w <= 32;
  endfunction
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int shift, input int out_w);
    logic signed [63:0] s, hi, lo;
    s = value >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/fm_sat_shift.sv
// fm_sat_shift: arithmetic right shift then clamp to a signed OUT_W range
module fm_sat_shift
  import fm_demod_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int SHIFT = 0,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  always_comb dout = OUT_W'(sat_shift(64'(din), SHIFT, OUT_W));
endmodule

// File: rtl/fm_discriminator.sv
// fm_discriminator: wrapped phase derivative with squelch, integrate-and-dump decimation and saturation
module fm_discriminator
  import fm_demod_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int MAG_W   = 16,
  parameter int DECIM   = 1,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = 16
) (
  input  logic             s00_axis_aclk,
  input  logic             s00_axis_aresetn,
  input  logic [MAG_W-1:0] squelch_thresh,
  input  logic             s00_axis_tvalid,
  output logic             s00_axis_tready,
  input  logic [31:0]      s00_axis_tdata,
  input  logic             s00_axis_tlast,
  input  logic [3:0]       s00_axis_tstrb,
  output logic             m00_axis_tvalid,
  input  logic             m00_axis_tready,
  output logic [31:0]      m00_axis_tdata,
  output logic             m00_axis_tlast,
  output logic [3:0]       m00_axis_tstrb
);
  localparam int ACC_W = ANGLE_W + 9;
  if (!params_ok(ANGLE_W, MAG_W, DECIM, SHIFT, OUT_W)) begin : g_bad_params
    $error("fm_discriminator: illegal parameter combination");
  end
  logic [ANGLE_W-1:0]      angle, prev_angle;
  logic [MAG_W-1:0]        mag;
  logic signed [ANGLE_W-1:0] diff;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [OUT_W-1:0] res;
  logic [7:0]              cnt;
  logic                    primed, accept, dump;
  logic                    unused_ok;
  assign unused_ok = ^{s00_axis_tstrb, s00_axis_tdata};
  assign m00_axis_tstrb = 4'hF;
  assign s00_axis_tready = m00_axis_tready || !m00_axis_tvalid;
  assign accept = s00_axis_tvalid && s00_axis_tready;
  assign angle = s00_axis_tdata[ANGLE_LSB +: ANGLE_W];
  assign mag = s00_axis_tdata[MAG_LSB +: MAG_W];
  // modulo subtraction read as signed gives the implicit phase unwrap
  assign diff = (!primed || (squelch_thresh != '0 && mag < squelch_thresh)) ? '0
              : $signed(angle - prev_angle);
  assign dump = accept && (cnt == 8'(DECIM - 1) || s00_axis_tlast);
  assign sum = acc + ACC_W'(diff);
  fm_sat_shift #(.IN_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat (
    .din (sum),
    .dout(res)
  );
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_aresetn) begin
      prev_angle      <= '0;
      primed          <= 1'b0;
      acc             <= '0;
      cnt             <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        prev_angle <= angle;
        primed     <= !s00_axis_tlast;
        acc        <= dump ? '0 : sum;
        cnt        <= dump ? '0 : cnt + 8'd1;
      end
      if (dump) begin
        m00_axis_tdata <= 32'(res);
        m00_axis_tlast <= s00_axis_tlast;
      end
      m00_axis_tvalid <= dump || (m00_axis_tvalid && !m00_axis_tready);
    end
  end
endmodule

// File: tb/tb_fm_discriminator.sv
// tb_fm_discriminator: directed checks across three parameterisations sharing one input stream
module tb_fm_discriminator;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] thresh = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_ready1, m_valid1, m_last1, s_ready4, m_valid4, m_last4, s_ready8, m_valid8, m_last8;
  logic [31:0] m_data1, m_data4, m_data8;
  logic [3:0]  m_strb1, m_strb4, m_strb8;
  int          checks = 0, failures = 0, n_out1 = 0;

  always #5 clk = ~clk;

  fm_discriminator #(.DECIM(1), .SHIFT(0), .OUT_W(16)) u1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .squelch_thresh(thresh),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(s_ready1), .s00_axis_tdata(s_data),
    .s00_axis_tlast(s_last), .s00_axis_tstrb(4'hF),
    .m00_axis_tvalid(m_valid1), .m00_axis_tready(m_ready), .m00_axis_tdata(m_data1),
    .m00_axis_tlast(m_last1), .m00_axis_tstrb(m_strb1));
  fm_discriminator #(.DECIM(4), .SHIFT(2), .OUT_W(16)) u4 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .squelch_thresh(thresh),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(s_ready4), .s00_axis_tdata(s_data),
    .s00_axis_tlast(s_last), .s00_axis_tstrb(4'hF),
    .m00_axis_tvalid(m_valid4), .m00_axis_tready(m_ready), .m00_axis_tdata(m_data4),
    .m00_axis_tlast(m_last4), .m00_axis_tstrb(m_strb4));
  fm_discriminator #(.DECIM(4), .SHIFT(0), .OUT_W(8)) u8 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .squelch_thresh(thresh),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(s_ready8), .s00_axis_tdata(s_data),
    .s00_axis_tlast(s_last), .s00_axis_tstrb(4'hF),
    .m00_axis_tvalid(m_valid8), .m00_axis_tready(m_ready), .m00_axis_tdata(m_data8),
    .m00_axis_tlast(m_last8), .m00_axis_tstrb(m_strb8));

  always @(posedge clk) n_out1 <= rst ? 0 : n_out1 + int'(m_valid1 && m_ready);

  task automatic do_reset;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; thresh = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic beat(input logic [15:0] ang, input logic [15:0] mag, input logic last);
    s_valid = 1'b1; s_data = {ang, mag}; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (m_valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b exp=0", m_valid1); end
    checks++; if (m_valid4 !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b exp=0", m_valid4); end
    checks++; if (m_data1 !== 32'h0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", m_data1); end
    checks++; if (m_last1 !== 1'b0) begin failures++; $display("FAIL reset_last1 got=%b exp=0", m_last1); end
    checks++; if (m_strb1 !== 4'hF) begin failures++; $display("FAIL reset_strb1 got=%h exp=f", m_strb1); end
    checks++; if (s_ready1 !== 1'b1) begin failures++; $display("FAIL reset_tready1 got=%b exp=1", s_ready1); end
  endtask

  task automatic test_decim1;
    logic [15:0] ang [3] = '{16'h1000, 16'h1400, 16'h1300};
    logic [31:0] exp [3] = '{32'h0, 32'h400, 32'hFFFFFF00};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      beat(ang[i], 16'h0200, 1'b0);
      checks++; if (m_valid1 !== 1'b1) begin failures++; $display("FAIL decim1_valid[%0d] got=%b exp=1", i, m_valid1); end
      checks++; if (m_data1 !== exp[i]) begin failures++; $display("FAIL decim1_data[%0d] got=%h exp=%h", i, m_data1, exp[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] ang [3] = '{16'hFF00, 16'h0100, 16'hFF00};
    logic [31:0] exp [3] = '{32'h0, 32'h200, 32'hFFFFFE00};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      beat(ang[i], 16'h0200, 1'b0);
      checks++; if (m_data1 !== exp[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, m_data1, exp[i]); end
    end
  endtask

  task automatic test_decim4;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      beat(16'(i * 256), 16'h0200, 1'b0);
      checks++; if (m_valid4 !== (i == 3 || i == 7)) begin failures++; $display("FAIL decim4_valid[%0d] got=%b exp=%b", i, m_valid4, (i == 3 || i == 7)); end
      if (i == 3) begin
        checks++; if (m_data4 !== 32'hC0) begin failures++; $display("FAIL decim4_dump1 got=%h exp=000000c0", m_data4); end
      end
      if (i == 7) begin
        checks++; if (m_data4 !== 32'h100) begin failures++; $display("FAIL decim4_dump2 got=%h exp=00000100", m_data4); end
      end
    end
  endtask

  task automatic test_squelch;
    logic [15:0] ang [3] = '{16'h0000, 16'h0400, 16'h0800};
    logic [15:0] mag [3] = '{16'h0200, 16'h0080, 16'h0200};
    logic [31:0] exp [3] = '{32'h0, 32'h0, 32'h400};
    do_reset;
    thresh = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      beat(ang[i], mag[i], 1'b0);
      checks++; if (m_data1 !== exp[i]) begin failures++; $display("FAIL squelch_data[%0d] got=%h exp=%h", i, m_data1, exp[i]); end
    end
  endtask

  task automatic test_sat_tlast;
    do_reset;
    beat(16'h0000, 16'h0200, 1'b0);
    beat(16'h0400, 16'h0200, 1'b1);
    checks++; if (m_valid8 !== 1'b1) begin failures++; $display("FAIL sat_pos_valid got=%b exp=1", m_valid8); end
    checks++; if (m_data8 !== 32'h7F) begin failures++; $display("FAIL sat_pos_data got=%h exp=0000007f", m_data8); end
    checks++; if (m_last8 !== 1'b1) begin failures++; $display("FAIL sat_pos_last got=%b exp=1", m_last8); end
    beat(16'h0400, 16'h0200, 1'b0);
    checks++; if (m_valid8 !== 1'b0) begin failures++; $display("FAIL tlast_partial_valid got=%b exp=0", m_valid8); end
    beat(16'h0000, 16'h0200, 1'b1);
    checks++; if (m_data8 !== 32'hFFFFFF80) begin failures++; $display("FAIL sat_neg_data got=%h exp=ffffff80", m_data8); end
    checks++; if (m_last8 !== 1'b1) begin failures++; $display("FAIL sat_neg_last got=%b exp=1", m_last8); end
    for (int i = 1; i <= 4; i++) beat(16'(i * 16), 16'h0200, 1'b0);
    checks++; if (m_data8 !== 32'h30) begin failures++; $display("FAIL unprimed_after_tlast got=%h exp=00000030", m_data8); end
    checks++; if (m_last8 !== 1'b0) begin failures++; $display("FAIL unprimed_last got=%b exp=0", m_last8); end
  endtask

  task automatic test_backpressure;
    do_reset;
    beat(16'h0000, 16'h0200, 1'b0);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = {16'h0100, 16'h0200};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (m_valid1 !== 1'b1 || m_data1 !== 32'h0 || s_ready1 !== 1'b0) begin
        failures++; $display("FAIL stall[%0d] got valid=%b data=%h tready=%b exp valid=1 data=0 tready=0", i, m_valid1, m_data1, s_ready1);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (m_valid1 !== 1'b1 || m_data1 !== 32'h100) begin failures++; $display("FAIL release got valid=%b data=%h exp valid=1 data=00000100", m_valid1, m_data1); end
    @(negedge clk);
    checks++; if (m_valid1 !== 1'b0) begin failures++; $display("FAIL release_nodup got=%b exp=0", m_valid1); end
    checks++; if (n_out1 !== 2) begin failures++; $display("FAIL release_count got=%0d exp=2", n_out1); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    beat(16'h0100, 16'h0200, 1'b0);
    beat(16'h0200, 16'h0200, 1'b0);
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (m_valid1 !== 1'b0 || m_data1 !== 32'h0) begin failures++; $display("FAIL midstall_reset got valid=%b data=%h exp valid=0 data=0", m_valid1, m_data1); end
    checks++; if (m_valid4 !== 1'b0) begin failures++; $display("FAIL midgroup_reset_valid got=%b exp=0", m_valid4); end
    m_ready = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      beat(16'(i * 256), 16'h0200, 1'b0);
      if (i == 3) begin
        checks++; if (m_valid1 !== 1'b1 || m_data1 !== 32'h0) begin failures++; $display("FAIL post_reset_unprimed got valid=%b data=%h exp valid=1 data=0", m_valid1, m_data1); end
      end
    end
    checks++; if (m_valid4 !== 1'b1 || m_data4 !== 32'hC0) begin failures++; $display("FAIL post_reset_group got valid=%b data=%h exp valid=1 data=000000c0", m_valid4, m_data4); end
  endtask

  initial begin
    test_reset;
    test_decim1;
    test_wrap;
    test_decim4;
    test_squelch;
    test_sat_tlast;
    test_backpressure;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
